// File: rtl/hft_fifo_pkg.sv
// Shared definitions for the market-data / order-path FIFO write side:
// FIFO geometry, the requester-index width helper and the write-arbiter
// state encoding.
package hft_fifo_pkg;

  localparam int FIFO_DATA_W = 128;
  localparam int FIFO_DEPTH  = 16;

  // Write-arbiter state: free to pick a new requester, or held by an owner
  // until its last beat (or a timeout).
  typedef enum logic [0:0] {
    IDLE   = 1'b0,
    LOCKED = 1'b1
  } arb_state_t;

  // Width of a requester index; never narrower than one bit.
  function automatic int id_width(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/fifo_wr_arbiter_rr_priority_sel.sv
// Rotating-priority selector: picks the first asserted bit of valid,
// searching rr_ptr, rr_ptr+1, ... modulo N. Purely combinational.
module rr_priority_sel
  import hft_fifo_pkg::*;
#(
  parameter int N  = 4,
  parameter int IW = id_width(N)
) (
  input  logic [N-1:0]  valid,
  input  logic [IW-1:0] rr_ptr,
  output logic [N-1:0]  grant,
  output logic [IW-1:0] idx,
  output logic          any_valid
);

  // Walk candidates from the farthest back to rr_ptr so the closest valid wins.
  always_comb begin
    int            pos;
    logic [IW-1:0] pos_i;
    // NOTE: every output gets a default before the loop; a path that leaves
    // one unassigned would infer a latch.
    grant     = '0;
    idx       = '0;
    any_valid = 1'b0;
    pos       = 0;
    pos_i     = '0;
    for (int k = N - 1; k >= 0; k--) begin
      pos   = (int'(rr_ptr) + k) % N;
      pos_i = IW'(pos);
      if (valid[pos_i]) begin
        grant        = '0;
        grant[pos_i] = 1'b1;
        idx          = pos_i;
        any_valid    = 1'b1;
      end
    end
  end

endmodule

// File: rtl/fifo_wr_arbiter.sv
// Packet-aware round-robin arbiter sharing the async FIFO write port between
// NUM_REQ requesters. Zero-latency datapath: the accepted beat is driven onto
// wr_data/wr_en in the same cycle. The grant is held for a whole message and
// a stalled owner is released after LOCK_TIMEOUT consecutive idle cycles.
module fifo_wr_arbiter
  import hft_fifo_pkg::*;
#(
  parameter int NUM_REQ      = 4,
  parameter int DATA_W       = FIFO_DATA_W,
  parameter int LOCK_TIMEOUT = 64,
  parameter int ID_W         = id_width(NUM_REQ)
) (
  input  logic                      wr_clk,
  input  logic                      reset,
  input  logic [NUM_REQ-1:0]        req_valid,
  input  logic [NUM_REQ*DATA_W-1:0] req_data,
  input  logic [NUM_REQ-1:0]        req_last,
  output logic [NUM_REQ-1:0]        req_ready,
  input  logic                      fifo_full,
  output logic [DATA_W-1:0]         wr_data,
  output logic                      wr_en,
  output logic [ID_W-1:0]           grant_id,
  output logic                      busy,
  output logic [31:0]               pkt_count,
  output logic [15:0]               abort_count
);

  // Idle counter only needs to hold 0 .. LOCK_TIMEOUT-1; the edge that would
  // reach LOCK_TIMEOUT is the release edge instead.
  localparam int CNT_W = (LOCK_TIMEOUT < 2) ? 1 : $clog2(LOCK_TIMEOUT);
  localparam logic [CNT_W-1:0] IDLE_LIMIT =
    (LOCK_TIMEOUT > 0) ? CNT_W'(LOCK_TIMEOUT - 1) : '0;
  localparam logic [ID_W-1:0] LAST_ID = ID_W'(NUM_REQ - 1);

  arb_state_t       state_q, state_d;
  logic [ID_W-1:0]  rr_ptr_q, rr_ptr_d;
  logic [ID_W-1:0]  owner_q, owner_d;
  logic [CNT_W-1:0] idle_cnt_q, idle_cnt_d;
  logic [31:0]      pkt_count_q, pkt_count_d;
  logic [15:0]      abort_count_q, abort_count_d;

  logic [NUM_REQ-1:0] rr_grant;
  logic [ID_W-1:0]    rr_idx;
  logic               rr_any;

  logic [ID_W-1:0]    sel_idx;
  logic [ID_W-1:0]    next_ptr;
  logic               sel_last;
  logic               xfer;
  logic               can_accept;
  logic [DATA_W-1:0]  beats [NUM_REQ];

  // Unpack the flat beat bus into one word per requester.
  for (genvar g = 0; g < NUM_REQ; g++) begin : g_unpack
    assign beats[g] = req_data[g*DATA_W +: DATA_W];
  end

  rr_priority_sel #(
    .N  (NUM_REQ),
    .IW (ID_W)
  ) u_rr_sel (
    .valid     (req_valid),
    .rr_ptr    (rr_ptr_q),
    .grant     (rr_grant),
    .idx       (rr_idx),
    .any_valid (rr_any)
  );

  // Select the active requester, drive ready and the zero-latency FIFO write.
  always_comb begin
    sel_idx    = (state_q == LOCKED) ? owner_q : rr_idx;
    can_accept = !fifo_full && !reset;
    req_ready  = '0;
    if (can_accept) begin
      if (state_q == LOCKED) begin
        req_ready[owner_q] = 1'b1;
      end else begin
        req_ready = rr_grant;
      end
    end
    xfer     = |(req_valid & req_ready);
    sel_last = req_last[sel_idx];
    next_ptr = (sel_idx == LAST_ID) ? '0 : sel_idx + ID_W'(1);
    wr_en    = xfer;
    wr_data  = beats[sel_idx];
    grant_id = sel_idx;
  end

  // Lock/release decisions, round-robin pointer, idle timeout and counters.
  always_comb begin
    logic pkt_done;
    logic abort_now;
    state_d    = state_q;
    rr_ptr_d   = rr_ptr_q;
    owner_d    = owner_q;
    idle_cnt_d = idle_cnt_q;
    pkt_done   = 1'b0;
    abort_now  = 1'b0;

    case (state_q)
      IDLE: begin
        idle_cnt_d = '0;
        if (xfer) begin
          if (sel_last) begin
            // Single-beat message: never locks.
            rr_ptr_d = next_ptr;
            pkt_done = 1'b1;
          end else begin
            state_d = LOCKED;
            owner_d = sel_idx;
          end
        end
      end

      LOCKED: begin
        if (xfer && sel_last) begin
          state_d    = IDLE;
          rr_ptr_d   = next_ptr;
          idle_cnt_d = '0;
          pkt_done   = 1'b1;
        end else if (req_valid[owner_q]) begin
          // Owner is presenting data, possibly stalled by fifo_full:
          // that is backpressure, not idleness.
          idle_cnt_d = '0;
        end else if (LOCK_TIMEOUT > 0) begin
          if (idle_cnt_q == IDLE_LIMIT) begin
            state_d    = IDLE;
            rr_ptr_d   = next_ptr;
            idle_cnt_d = '0;
            abort_now  = 1'b1;
          end else begin
            idle_cnt_d = idle_cnt_q + CNT_W'(1);
          end
        end
      end

      default: begin
        state_d    = IDLE;
        idle_cnt_d = '0;
      end
    endcase

    pkt_count_d   = pkt_done ? pkt_count_q + 32'd1 : pkt_count_q;
    abort_count_d = (abort_now && (abort_count_q != 16'hFFFF))
                    ? abort_count_q + 16'd1 : abort_count_q;
  end

  // State registers; reset drops any lock immediately.
  always_ff @(posedge wr_clk or posedge reset) begin
    if (reset) begin
      state_q       <= IDLE;
      rr_ptr_q      <= '0;
      owner_q       <= '0;
      idle_cnt_q    <= '0;
      pkt_count_q   <= '0;
      abort_count_q <= '0;
    end else begin
      // NOTE: non-blocking assignments so every flop samples the values of
      // the previous cycle, independent of statement order.
      state_q       <= state_d;
      rr_ptr_q      <= rr_ptr_d;
      owner_q       <= owner_d;
      idle_cnt_q    <= idle_cnt_d;
      pkt_count_q   <= pkt_count_d;
      abort_count_q <= abort_count_d;
    end
  end

  assign busy        = (state_q == LOCKED);
  assign pkt_count   = pkt_count_q;
  assign abort_count = abort_count_q;

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// Self-checking bench for fifo_wr_arbiter: per-requester beat queues feed the
// DUT, a message-level reference model is compared on every falling edge, and
// directed scenarios pin literal values.
module tb_fifo_wr_arbiter;
  localparam int N   = 4;
  localparam int DW  = 128;
  localparam int TMO = 64;
  localparam int QD  = 64;

  logic              wr_clk = 1'b0;
  logic              reset  = 1'b1;
  logic [N-1:0]      req_valid;
  logic [N*DW-1:0]   req_data;
  logic [N-1:0]      req_last;
  logic [N-1:0]      req_ready;
  logic              fifo_full = 1'b0;
  logic [DW-1:0]     wr_data;
  logic              wr_en;
  logic [1:0]        grant_id;
  logic              busy;
  logic [31:0]       pkt_count;
  logic [15:0]       abort_count;

  fifo_wr_arbiter #(
    .NUM_REQ      (N),
    .DATA_W       (DW),
    .LOCK_TIMEOUT (TMO),
    .ID_W         (2)
  ) dut (
    .wr_clk      (wr_clk),
    .reset       (reset),
    .req_valid   (req_valid),
    .req_data    (req_data),
    .req_last    (req_last),
    .req_ready   (req_ready),
    .fifo_full   (fifo_full),
    .wr_data     (wr_data),
    .wr_en       (wr_en),
    .grant_id    (grant_id),
    .busy        (busy),
    .pkt_count   (pkt_count),
    .abort_count (abort_count)
  );

  always #5 wr_clk = ~wr_clk;

  int total = 0;
  int bad   = 0;

  task automatic check(input string name, input logic [DW-1:0] act,
                       input logic [DW-1:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- requester beat queues ----------------
  logic [DW-1:0] qd [N][QD];
  logic          ql [N][QD];
  int            qh [N];
  int            qt [N];

  task automatic push(input int r, input logic [DW-1:0] d, input logic l);
    if (qt[r] < QD) begin
      qd[r][qt[r]] = d;
      ql[r][qt[r]] = l;
      qt[r]++;
    end
  endtask

  task automatic clear_all();
    for (int i = 0; i < N; i++) begin
      qh[i] = 0;
      qt[i] = 0;
    end
  endtask

  task automatic present();
    for (int i = 0; i < N; i++) begin
      if (qh[i] < qt[i]) begin
        req_valid[i]           = 1'b1;
        req_data[i*DW +: DW]   = qd[i][qh[i]];
        req_last[i]            = ql[i][qh[i]];
      end else begin
        req_valid[i]           = 1'b0;
        req_data[i*DW +: DW]   = '0;
        req_last[i]            = 1'b0;
      end
    end
  endtask

  // Source driver: pop accepted beats and present the next head at posedge+1.
  initial begin
    bit [N-1:0] acc;
    clear_all();
    present();
    forever begin
      @(negedge wr_clk);
      acc = req_valid & req_ready;
      @(posedge wr_clk);
      #1;
      for (int i = 0; i < N; i++)
        if (acc[i] && qh[i] < qt[i]) qh[i]++;
      present();
    end
  end

  // ---------------- reference model + per-cycle compare ----------------
  initial begin
    bit          m_locked;
    int          m_owner, m_next, m_idle, m_aborts;
    logic [31:0] m_pkts;
    int          sel, j;
    bit          any;
    logic [N-1:0] exp_ready;
    bit          exp_xfer;
    m_locked = 0; m_owner = 0; m_next = 0; m_idle = 0; m_aborts = 0; m_pkts = '0;
    forever begin
      @(negedge wr_clk);
      if (reset) begin
        m_locked = 0; m_owner = 0; m_next = 0; m_idle = 0; m_aborts = 0; m_pkts = '0;
      end
      check("busy", 128'(busy), 128'(m_locked));
      check("pkt_count", 128'(pkt_count), 128'(m_pkts));
      check("abort_count", 128'(abort_count), 128'(m_aborts));

      // Who may write this cycle: the owner, or the first valid from m_next.
      sel = m_owner;
      any = m_locked;
      if (!m_locked) begin
        for (int k = 0; k < N; k++) begin
          j = (m_next + k) % N;
          if (!any && req_valid[j]) begin
            sel = j;
            any = 1;
          end
        end
      end
      exp_ready = '0;
      if (!reset && !fifo_full && any) exp_ready[sel] = 1'b1;
      exp_xfer = exp_ready[sel] && req_valid[sel];

      check("req_ready", 128'(req_ready), 128'(exp_ready));
      check("wr_en", 128'(wr_en), 128'(exp_xfer));
      if (exp_xfer) begin
        check("grant_id", 128'(grant_id), 128'(sel));
        check("wr_data", wr_data, req_data[sel*DW +: DW]);
      end

      if (!reset) begin
        if (exp_xfer && req_last[sel]) begin
          m_pkts   = m_pkts + 32'd1;
          m_next   = (sel + 1) % N;
          m_locked = 0;
        end else if (exp_xfer) begin
          m_locked = 1;
          m_owner  = sel;
          m_idle   = 0;
        end else if (m_locked) begin
          if (req_valid[m_owner]) begin
            m_idle = 0;
          end else begin
            m_idle++;
            if (m_idle == TMO) begin
              m_locked = 0;
              m_next   = (m_owner + 1) % N;
              m_idle   = 0;
              if (m_aborts < 65535) m_aborts++;
            end
          end
        end
      end
    end
  end

  task automatic tick();
    @(posedge wr_clk);
    #2;
  endtask

  // ---------------- directed scenarios ----------------
  initial begin
    tick();
    @(negedge wr_clk);
    check("rst_wen", 128'(wr_en), 128'h0);
    check("rst_busy", 128'(busy), 128'h0);
    check("rst_pkt", 128'(pkt_count), 128'h0);
    tick();
    reset = 1'b0;

    // 1: three-beat message from req0
    push(0, 128'hA1, 1'b0); push(0, 128'hA2, 1'b0); push(0, 128'hA3, 1'b1);
    tick(); @(negedge wr_clk);
    check("t1_wen0", 128'(wr_en), 128'h1);
    check("t1_data0", wr_data, 128'hA1);
    check("t1_gid0", 128'(grant_id), 128'h0);
    tick(); @(negedge wr_clk);
    check("t1_data1", wr_data, 128'hA2);
    check("t1_busy1", 128'(busy), 128'h1);
    tick(); @(negedge wr_clk);
    check("t1_data2", wr_data, 128'hA3);
    check("t1_busy2", 128'(busy), 128'h1);
    tick(); @(negedge wr_clk);
    check("t1_busy_end", 128'(busy), 128'h0);
    check("t1_pkt", 128'(pkt_count), 128'h1);
    check("t1_wen_end", 128'(wr_en), 128'h0);

    // 2: all four hold single-beat messages from reset
    tick();
    reset = 1'b1;
    clear_all();
    for (int r = 0; r < N; r++)
      for (int k = 0; k < 2; k++)
        push(r, 128'(512 + r * 16 + k), 1'b1);
    tick();
    reset = 1'b0;
    for (int i = 0; i < 6; i++) begin
      @(negedge wr_clk);
      check("t2_gid", 128'(grant_id), 128'(i % N));
      check("t2_wen", 128'(wr_en), 128'h1);
      tick();
    end
    tick();

    // 3: req1 locked mid-message while req2 waits
    push(1, 128'hB0, 1'b0); push(1, 128'hB1, 1'b0);
    push(1, 128'hB2, 1'b0); push(1, 128'hB3, 1'b1);
    tick(); @(negedge wr_clk);
    check("t3_gid_b0", 128'(grant_id), 128'h1);
    check("t3_data_b0", wr_data, 128'hB0);
    tick();
    push(2, 128'hC0, 1'b1);
    @(negedge wr_clk);
    check("t3_data_b1", wr_data, 128'hB1);
    tick(); @(negedge wr_clk);
    check("t3_rdy2_b2", 128'(req_ready[2]), 128'h0);
    check("t3_data_b2", wr_data, 128'hB2);
    tick(); @(negedge wr_clk);
    check("t3_rdy2_b3", 128'(req_ready[2]), 128'h0);
    check("t3_data_b3", wr_data, 128'hB3);
    tick(); @(negedge wr_clk);
    check("t3_gid_c0", 128'(grant_id), 128'h2);
    check("t3_data_c0", wr_data, 128'hC0);
    check("t3_wen_c0", 128'(wr_en), 128'h1);
    tick();

    // 4: fifo_full stalls a locked req3 for five cycles
    push(3, 128'hD0, 1'b0); push(3, 128'hD1, 1'b0); push(3, 128'hD2, 1'b1);
    tick(); @(negedge wr_clk);
    check("t4_data_d0", wr_data, 128'hD0);
    tick();
    fifo_full = 1'b1;
    for (int k = 0; k < 5; k++) begin
      @(negedge wr_clk);
      check("t4_rdy_full", 128'(req_ready), 128'h0);
      check("t4_wen_full", 128'(wr_en), 128'h0);
      check("t4_abort", 128'(abort_count), 128'h0);
      tick();
    end
    fifo_full = 1'b0;
    @(negedge wr_clk);
    check("t4_wen_d1", 128'(wr_en), 128'h1);
    check("t4_data_d1", wr_data, 128'hD1);
    tick(); @(negedge wr_clk);
    check("t4_data_d2", wr_data, 128'hD2);
    check("t4_pkt", 128'(pkt_count), 128'd10);
    tick();

    // 5: req0 locks then goes silent; timeout hands the port to req2
    push(0, 128'hE0, 1'b0); push(2, 128'hF0, 1'b1);
    tick(); @(negedge wr_clk);
    check("t5_gid_e0", 128'(grant_id), 128'h0);
    check("t5_data_e0", wr_data, 128'hE0);
    for (int k = 1; k <= TMO; k++) begin
      tick(); @(negedge wr_clk);
      check("t5_busy_idle", 128'(busy), 128'h1);
      check("t5_wen_idle", 128'(wr_en), 128'h0);
    end
    tick(); @(negedge wr_clk);
    check("t5_busy_rel", 128'(busy), 128'h0);
    check("t5_abort", 128'(abort_count), 128'h1);
    check("t5_gid_f0", 128'(grant_id), 128'h2);
    check("t5_data_f0", wr_data, 128'hF0);
    check("t5_wen_f0", 128'(wr_en), 128'h1);
    check("t5_pkt", 128'(pkt_count), 128'd11);
    tick();

    // 6: reset while req1 is locked
    push(1, 128'h10, 1'b0); push(1, 128'h11, 1'b0); push(1, 128'h12, 1'b1);
    tick(); @(negedge wr_clk);
    check("t6_gid_g0", 128'(grant_id), 128'h1);
    tick();
    reset = 1'b1;
    clear_all();
    push(0, 128'h20, 1'b1);
    push(2, 128'h22, 1'b1);
    @(negedge wr_clk);
    check("t6_busy_rst", 128'(busy), 128'h0);
    check("t6_pkt_rst", 128'(pkt_count), 128'h0);
    check("t6_abort_rst", 128'(abort_count), 128'h0);
    check("t6_wen_rst", 128'(wr_en), 128'h0);
    check("t6_rdy_rst", 128'(req_ready), 128'h0);
    tick();
    reset = 1'b0;
    @(negedge wr_clk);
    check("t6_gid_first", 128'(grant_id), 128'h0);
    check("t6_data_first", wr_data, 128'h20);
    check("t6_wen_first", 128'(wr_en), 128'h1);
    tick(); @(negedge wr_clk);
    check("t6_gid_second", 128'(grant_id), 128'h2);
    check("t6_data_second", wr_data, 128'h22);
    tick();
    tick();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
